// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
//   op_t    : operation encoding presented on op_i
//   state_t : sequencer states (idle, iterate, sign fix / writeback)
//   Div0Lo  : LO value produced by a divide by zero (all ones, sliced to WIDTH)
package muldiv_pkg;

  typedef enum logic [1:0] {
    OpMult  = 2'd0,
    OpMultu = 2'd1,
    OpDiv   = 2'd2,
    OpDivu  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_t;

  // Wide enough for any supported WIDTH; users take the low WIDTH bits.
  localparam int unsigned MaxWidth = 64;
  localparam logic [MaxWidth-1:0] Div0Lo = '1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i/o  : upper half (partial product high / partial remainder)
//   lo_i/o   : lower half (multiplier shifting out / dividend out, quotient in)
//   b_i      : multiplicand magnitude / divisor magnitude
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier bit is set, then
    // shift the whole {carry, acc, lo} right by one.
    mul_sum   = {1'b0, acc_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    // Divide: bring the next dividend bit into the remainder and trial-subtract.
    // The extra top bit of div_diff is the borrow.
    div_shift = {acc_i, lo_i[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_i};
    div_ge    = ~div_diff[WIDTH+1];

    if (is_div_i) begin
      acc_o = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_o  = {lo_i[WIDTH-2:0], div_ge};
    end else begin
      acc_o = mul_sum[WIDTH:1];
      lo_o  = {mul_sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with architectural HI/LO.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   start_i, op_i      : launch op (muldiv_pkg::op_t) on a_i/b_i; ignored while busy
//   a_i, b_i           : multiplicand/dividend, multiplier/divisor
//   cancel_i           : abort in-flight op, no result written
//   hi_we_i, lo_we_i   : direct HI/LO writes from wdata_i (MTHI/MTLO)
//   busy_o, done_o     : op in flight / one-cycle completion pulse
//   hi_o, lo_o         : HI and LO registers
// Operands are reduced to magnitudes on start, iterated WIDTH times, and the
// signs are applied in a single fix-up cycle before HI/LO are written.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  op_t              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_acc_q, lo_acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             in_signed;
  logic             in_sa, in_sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             is_div;
  logic [WIDTH-1:0] step_acc, step_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0] quo_res, rem_res;

  assign in_signed = (op_i == OpMult) || (op_i == OpDiv);
  assign in_sa     = in_signed & a_i[WIDTH-1];
  assign in_sb     = in_signed & b_i[WIDTH-1];
  assign abs_a     = in_sa ? -a_i : a_i;
  assign abs_b     = in_sb ? -b_i : b_i;
  assign is_div    = (op_q == OpDiv) || (op_q == OpDivu);

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i(is_div),
    .acc_i   (acc_q),
    .lo_i    (lo_acc_q),
    .b_i     (b_q),
    .acc_o   (step_acc),
    .lo_o    (step_lo)
  );

  // Sign fix-up. Quotient is negative when signs differ; remainder follows the
  // dividend. INT_MIN / -1 wraps naturally through the magnitude path.
  always_comb begin
    prod_mag = {acc_q, lo_acc_q};
    prod_res = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
    quo_res  = (sa_q ^ sb_q) ? -lo_acc_q : lo_acc_q;
    rem_res  = sa_q ? -acc_q : acc_q;
    // The remainder path already yields HI = a on b = 0; only LO needs forcing.
    if (div0_q) begin
      quo_res = Div0Lo[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_acc_d = lo_acc_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    hi_d     = hi_we_i ? wdata_i : hi_q;
    lo_d     = lo_we_i ? wdata_i : lo_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !cancel_i) begin
          state_d  = StRun;
          op_d     = op_i;
          cnt_d    = CntW'(WIDTH - 1);
          acc_d    = '0;
          lo_acc_d = abs_a;
          b_d      = abs_b;
          sa_d     = in_sa;
          sb_d     = in_sb;
          div0_d   = (b_i == '0);
        end
      end
      StRun: begin
        if (cancel_i) begin
          state_d = StIdle;
        end else begin
          acc_d    = step_acc;
          lo_acc_d = step_lo;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!cancel_i) begin
          done_d = 1'b1;
          // Result overrides any MTHI/MTLO on the same edge.
          if (is_div) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            hi_d = prod_res[2*WIDTH-1:WIDTH];
            lo_d = prod_res[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= OpMult;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_acc_q <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_acc_q <= lo_acc_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
